// File: rtl/extbus_pkg.sv
// Shared definitions for the VERA-style external host bus (initiator and responder sides).
package extbus_pkg;

   localparam int EXTBUS_AW = 5;
   localparam int EXTBUS_DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      HIGH,
      HOLD
   } extbus_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/extbus_master_if.sv
// Request/response handshake plus the unidirectional host-bus signals.
// The bidirectional data bus stays a plain inout on the master module.
interface extbus_master_if;
   import extbus_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [EXTBUS_AW-1:0] req_addr;
   logic [EXTBUS_DW-1:0] req_wdata;
   logic                 rsp_valid;
   logic [EXTBUS_DW-1:0] rsp_rdata;
   logic                 extbus_cs_n;
   logic                 extbus_phi2;
   logic                 extbus_rw;
   logic [EXTBUS_AW-1:0] extbus_a;
   logic                 extbus_irq_n;
   logic                 irq;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, extbus_irq_n,
      output req_ready, rsp_valid, rsp_rdata,
      output extbus_cs_n, extbus_phi2, extbus_rw, extbus_a, irq
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, extbus_irq_n,
      input  req_ready, rsp_valid, rsp_rdata,
      input  extbus_cs_n, extbus_phi2, extbus_rw, extbus_a, irq
   );

endinterface

// File: rtl/extbus_master_sync2.sv
// Generic two-flop synchronizer with asynchronous reset to a chosen value.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of an asynchronous level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/extbus_master.sv
// Host-bus initiator: turns single-word requests into phi2-timed bus cycles
// (SETUP with phi2 low, HIGH with phi2 high, HOLD after phi2 falls).
module extbus_master
   import extbus_pkg::*;
#(
   parameter int PHI2_LOW_CYCLES  = 6,
   parameter int PHI2_HIGH_CYCLES = 6,
   parameter int HOLD_CYCLES      = 1
) (
   input  logic                 clk25,
   input  logic                 reset,
   extbus_master_if.master      bus,
   inout  wire  [EXTBUS_DW-1:0] extbus_d
);

   localparam int MAX_CYC = max3(PHI2_LOW_CYCLES, PHI2_HIGH_CYCLES, HOLD_CYCLES);
   localparam int CW      = $clog2(MAX_CYC) + 1;

   if (PHI2_LOW_CYCLES < 1 || PHI2_HIGH_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_err
      $error("extbus_master: PHI2_LOW_CYCLES, PHI2_HIGH_CYCLES and HOLD_CYCLES must be >= 1");
   end

   extbus_state_e        state, state_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic                 write_q, write_nx;
   logic [EXTBUS_DW-1:0] wdata_q, wdata_nx;
   logic                 d_en, d_en_nx;
   logic                 ready_nx, rsp_valid_nx;
   logic [EXTBUS_DW-1:0] rdata_nx;
   logic                 cs_n_nx, phi2_nx, rw_nx;
   logic [EXTBUS_AW-1:0] a_nx;

   assign extbus_d = d_en ? wdata_q : 'z;

   // Next-state and next-output decode; every bus output is registered from here.
   always_comb begin
      state_nx     = state;
      cnt_nx       = (cnt != '0) ? cnt - CW'(1) : cnt;
      write_nx     = write_q;
      wdata_nx     = wdata_q;
      d_en_nx      = d_en;
      ready_nx     = bus.req_ready;
      rsp_valid_nx = 1'b0;
      rdata_nx     = bus.rsp_rdata;
      cs_n_nx      = bus.extbus_cs_n;
      phi2_nx      = bus.extbus_phi2;
      rw_nx        = bus.extbus_rw;
      a_nx         = bus.extbus_a;
      unique case (state)
         IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               state_nx = SETUP;
               cnt_nx   = CW'(PHI2_LOW_CYCLES - 1);
               write_nx = bus.req_write;
               wdata_nx = bus.req_wdata;
               ready_nx = 1'b0;
               cs_n_nx  = 1'b0;
               a_nx     = bus.req_addr;
               rw_nx    = ~bus.req_write;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_nx = HIGH;
               cnt_nx   = CW'(PHI2_HIGH_CYCLES - 1);
               phi2_nx  = 1'b1;
               d_en_nx  = write_q;
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               state_nx = HOLD;
               cnt_nx   = CW'(HOLD_CYCLES - 1);
               phi2_nx  = 1'b0;
               // Read data is taken on the same edge that drops phi2.
               if (!write_q) begin
                  rdata_nx = extbus_d;
               end
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_nx     = IDLE;
               d_en_nx      = 1'b0;
               cs_n_nx      = 1'b1;
               rw_nx        = 1'b1;
               ready_nx     = 1'b1;
               rsp_valid_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, counter, latched request and registered bus outputs.
   always_ff @(posedge clk25 or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         write_q         <= 1'b0;
         wdata_q         <= '0;
         d_en            <= 1'b0;
         bus.req_ready   <= 1'b1;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.extbus_cs_n <= 1'b1;
         bus.extbus_phi2 <= 1'b0;
         bus.extbus_rw   <= 1'b1;
         bus.extbus_a    <= '0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         write_q         <= write_nx;
         wdata_q         <= wdata_nx;
         d_en            <= d_en_nx;
         bus.req_ready   <= ready_nx;
         bus.rsp_valid   <= rsp_valid_nx;
         bus.rsp_rdata   <= rdata_nx;
         bus.extbus_cs_n <= cs_n_nx;
         bus.extbus_phi2 <= phi2_nx;
         bus.extbus_rw   <= rw_nx;
         bus.extbus_a    <= a_nx;
      end
   end

   sync2 #(.RESET_VAL(1'b0)) u_irq_sync (
      .clk (clk25),
      .rst (reset),
      .d   (~bus.extbus_irq_n),
      .q   (bus.irq)
   );

endmodule
